// File: rtl/imem_arbiter_if.sv
// Fetch and load request/response bundle for the instruction memory arbiter.
// master = CPU fetch unit / loader side, slave = arbiter side.
interface imem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     fetch_req;
    logic [ADDRESS_WIDTH-1:0] fetch_addr;
    logic                     fetch_gnt;
    logic                     fetch_valid;
    logic [DATA_WIDTH-1:0]    fetch_data;
    logic                     fetch_err;
    logic                     load_req;
    logic [ADDRESS_WIDTH-1:0] load_addr;
    logic [7:0]               load_byte;
    logic                     load_gnt;
    logic                     load_err;

    modport master (
        output fetch_req, fetch_addr,
        output load_req, load_addr, load_byte,
        input  fetch_gnt, fetch_valid, fetch_data, fetch_err,
        input  load_gnt, load_err
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_req, load_addr, load_byte,
        output fetch_gnt, fetch_valid, fetch_data, fetch_err,
        output load_gnt, load_err
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: CPU fetches vs. byte loader,
// load priority with a bounded burst so a waiting fetch cannot starve.
module imem_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE           = 14,
    parameter int LOAD_BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_arbiter_if.slave         bus,
    output logic [SIZE-1:0]       mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD =
        ADDRESS_WIDTH'((64'd1 << SIZE) - 64'd4);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_BYTE =
        ADDRESS_WIDTH'((64'd1 << SIZE) - 64'd1);
    localparam logic [2:0] BURST_MAX = 3'(LOAD_BURST_MAX);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [2:0]            burst_cnt;
    logic                  burst_full;
    logic                  fetch_legal;
    logic                  load_legal;
    logic                  fetch_gnt;
    logic                  load_gnt;
    logic                  valid_q;
    logic                  ferr_q;
    logic                  lerr_q;
    logic [DATA_WIDTH-1:0] data_q;

    assign burst_full  = (burst_cnt == BURST_MAX);
    assign fetch_legal = (bus.fetch_addr[1:0] == 2'b00)
                      && (bus.fetch_addr <= LAST_WORD);
    assign load_legal  = (bus.load_addr <= LAST_BYTE);

    // Arbitration: load first, unless a waiting fetch has seen a full burst.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!rst) begin
            if (bus.load_req && !(bus.fetch_req && burst_full))
                load_gnt = 1'b1;
            else if (bus.fetch_req)
                fetch_gnt = 1'b1;
        end
    end

    // Memory port: illegal fetches and dropped loads leave the port idle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (fetch_gnt && fetch_legal) begin
            mem_addr = bus.fetch_addr[SIZE-1:0];
        end else if (load_gnt && load_legal) begin
            mem_addr  = bus.load_addr[SIZE-1:0];
            mem_we    = 1'b1;
            mem_wdata = bus.load_byte;
        end
    end

    // Count loads that overtook a waiting fetch; any fetch grant or idle fetch side resets it.
    always_ff @(posedge clk) begin
        if (rst)
            burst_cnt <= 3'd0;
        else if (!bus.fetch_req || fetch_gnt)
            burst_cnt <= 3'd0;
        else if (load_gnt && !burst_full)
            burst_cnt <= burst_cnt + 3'd1;
    end

    // One-cycle fetch response and load error pulse; data holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= fetch_gnt;
            ferr_q  <= fetch_gnt && !fetch_legal;
            lerr_q  <= load_gnt && !load_legal;
            if (fetch_gnt)
                data_q <= fetch_legal ? mem_rdata : NOP;
        end
    end

    // Reset masks the response immediately so an in-flight fetch never surfaces.
    assign bus.fetch_gnt   = fetch_gnt;
    assign bus.load_gnt    = load_gnt;
    assign bus.fetch_valid = valid_q && !rst;
    assign bus.fetch_err   = ferr_q && !rst;
    assign bus.load_err    = lerr_q && !rst;
    assign bus.fetch_data  = rst ? '0 : data_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_imem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SIZE = 14;
    localparam int BMAX = 4;
    localparam int MEM  = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] mem_addr;
    logic            mem_we;
    logic [7:0]      mem_wdata;
    logic [DW-1:0]   mem_rdata;

    imem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SIZE(SIZE),
        .LOAD_BURST_MAX(BMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0:       return 8'h13;
            1:       return 8'h05;
            2, 3:    return 8'h00;
            8:       return 8'h44;
            9:       return 8'h33;
            10:      return 8'h22;
            11:      return 8'h11;
            12:      return 8'h88;
            13:      return 8'h77;
            14:      return 8'h66;
            15:      return 8'h55;
            16380:   return 8'hEF;
            16381:   return 8'hBE;
            16382:   return 8'hAD;
            16383:   return 8'hDE;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // Environment memory array driven by the DUT's memory port.
    logic [7:0] ram [MEM];
    logic       ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < MEM; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = {ram[mem_addr + SIZE'(3)], ram[mem_addr + SIZE'(2)],
                        ram[mem_addr + SIZE'(1)], ram[mem_addr]};

    // Behavioural model: expected outputs from the arbitration rules.
    logic [7:0]  ref_mem [MEM];
    bit          ref_ready = 1'b0;
    int          m_burst;
    logic        m_valid, m_err, m_lerr;
    logic [31:0] m_data;

    always @(negedge clk) begin
        logic        efg, elg, ewe, legal;
        logic [31:0] eaddr;
        logic [7:0]  ewd;
        int          a;
        if (!ref_ready) begin
            for (int i = 0; i < MEM; i++) ref_mem[i] = init_byte(i);
            ref_ready = 1'b1;
            m_burst = 0;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_lerr = 1'b0;
            m_data = 32'h0;
        end
        if (rst) begin
            efg = 1'b0;
            elg = 1'b0;
        end else begin
            efg = bus.fetch_req && (!bus.load_req || m_burst == BMAX);
            elg = bus.load_req && !efg;
        end
        legal = (bus.fetch_addr % 4 == 0) && (bus.fetch_addr <= 32'(MEM - 4));
        ewe = 1'b0;
        eaddr = 32'h0;
        ewd = 8'h00;
        if (efg && legal) eaddr = bus.fetch_addr;
        if (elg && bus.load_addr < 32'(MEM)) begin
            ewe = 1'b1;
            eaddr = bus.load_addr;
            ewd = bus.load_byte;
        end
        chk("fetch_gnt", bus.fetch_gnt, efg);
        chk("load_gnt", bus.load_gnt, elg);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_wdata", mem_wdata, ewd);
        chk("fetch_valid", bus.fetch_valid, rst ? 1'b0 : m_valid);
        chk("fetch_err", bus.fetch_err, rst ? 1'b0 : m_err);
        chk("load_err", bus.load_err, rst ? 1'b0 : m_lerr);
        chk("fetch_data", bus.fetch_data, rst ? 32'h0 : m_data);
        if (rst) begin
            m_valid = 1'b0;
            m_err = 1'b0;
            m_lerr = 1'b0;
            m_data = 32'h0;
            m_burst = 0;
        end else begin
            m_valid = efg;
            m_err = efg && !legal;
            m_lerr = elg && bus.load_addr >= 32'(MEM);
            if (efg) begin
                if (legal) begin
                    a = int'(bus.fetch_addr);
                    m_data = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
                end else begin
                    m_data = 32'h0000_0013;
                end
            end
            if (ewe) ref_mem[eaddr] = ewd;
            if (!bus.fetch_req || efg) m_burst = 0;
            else if (elg && m_burst < BMAX) m_burst++;
        end
    end

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                         input logic [31:0] la, input logic [7:0] lb);
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.load_req   = lr;
        bus.load_addr  = la;
        bus.load_byte  = lb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [31:0] fa_t [3] = '{32'h2, 32'h3FFD, 32'h3FFC};
    logic        fe_t [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] fd_t [3] = '{32'h13, 32'h13, 32'hDEADBEEF};
    logic [7:0]  lb_t [4] = '{8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        string       pat;
        logic        fr, lr;
        logic [31:0] fa, la;
        rst = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 32'h0, 8'h00);
        repeat (2) step();
        sample();
        chk("rst_fetch_gnt", bus.fetch_gnt, 1'b0);
        chk("rst_load_gnt", bus.load_gnt, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_fetch_valid", bus.fetch_valid, 1'b0);
        chk("rst_fetch_data", bus.fetch_data, 32'h0);
        step();

        rst = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 32'h0, 8'h00);
        sample();
        chk("first_fetch_gnt", bus.fetch_gnt, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        sample();
        chk("first_valid", bus.fetch_valid, 1'b1);
        chk("first_data", bus.fetch_data, 32'h0000_0513);
        chk("first_err", bus.fetch_err, 1'b0);
        step();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, fa_t[i], 1'b0, 32'h0, 8'h00);
            sample();
            chk("bound_gnt", bus.fetch_gnt, 1'b1);
            chk("bound_we", mem_we, 1'b0);
            step();
            drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
            sample();
            chk("bound_err", bus.fetch_err, fe_t[i]);
            chk("bound_data", bus.fetch_data, fd_t[i]);
            step();
        end

        drive(1'b1, 32'h20, 1'b1, 32'h100, 8'hA5);
        pat = "";
        for (int i = 0; i < 10; i++) begin
            sample();
            pat = {pat, bus.fetch_gnt ? "F" : (bus.load_gnt ? "L" : "-")};
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        checks++;
        if (pat != "LLLLFLLLLF") begin
            errors++;
            $display("FAIL burst_pattern: got %s, expected LLLLFLLLLF", pat);
        end
        step();

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h10 + 32'(i), lb_t[i]);
            sample();
            chk("load_gnt_d", bus.load_gnt, 1'b1);
            chk("load_we_d", mem_we, 1'b1);
            step();
        end
        drive(1'b1, 32'h10, 1'b0, 32'h0, 8'h00);
        sample();
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        sample();
        chk("loaded_word", bus.fetch_data, 32'h0010_0093);
        step();

        drive(1'b0, 32'h0, 1'b1, 32'h4000, 8'h5A);
        sample();
        chk("oor_load_gnt", bus.load_gnt, 1'b1);
        chk("oor_load_we", mem_we, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        sample();
        chk("oor_load_err", bus.load_err, 1'b1);
        step();

        drive(1'b1, 32'h0, 1'b0, 32'h0, 8'h00);
        sample();
        chk("pre_rst_gnt", bus.fetch_gnt, 1'b1);
        step();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        sample();
        chk("rst_kill_valid", bus.fetch_valid, 1'b0);
        chk("rst_kill_data", bus.fetch_data, 32'h0);
        step();
        rst = 1'b0;
        sample();
        chk("post_rst_valid", bus.fetch_valid, 1'b0);
        step();

        drive(1'b1, 32'h8, 1'b0, 32'h0, 8'h00);
        sample();
        step();
        drive(1'b1, 32'hC, 1'b0, 32'h0, 8'h00);
        sample();
        chk("b2b_valid0", bus.fetch_valid, 1'b1);
        chk("b2b_data0", bus.fetch_data, 32'h1122_3344);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        sample();
        chk("b2b_valid1", bus.fetch_valid, 1'b1);
        chk("b2b_data1", bus.fetch_data, 32'h5566_7788);
        step();

        repeat (3000) begin
            rst = ($urandom_range(0, 63) == 0);
            fr = ($urandom_range(0, 99) < 60);
            lr = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 9))
                0:       fa = $urandom;
                1:       fa = 32'($urandom_range(0, MEM - 1));
                2:       fa = 32'(MEM - 4) + 32'($urandom_range(0, 7));
                default: fa = 32'($urandom_range(0, 63)) << 2;
            endcase
            case ($urandom_range(0, 9))
                0:       la = $urandom;
                1:       la = 32'(MEM) + 32'($urandom_range(0, 3));
                2:       la = 32'(MEM - 1) - 32'($urandom_range(0, 3));
                default: la = 32'($urandom_range(0, 255));
            endcase
            drive(fr, fa, lr, la, 8'($urandom));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        step();
        sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
